// File: rtl/barrel_shift_sequencer.sv
// Rotates a word by an arbitrary amount using an external single-pass rotator,
// issuing at most N-1 positions per cycle until the requested total is consumed.
module barrel_shift_sequencer #(
  parameter int N     = 8,
  parameter int AMT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [N-1:0]         req_data_i,
  input  logic [AMT_W-1:0]     req_amount_i,
  input  logic                 req_direction_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic [N-1:0]         resp_data_o,
  output logic [N-1:0]         data_o,
  output logic [$clog2(N)-1:0] shift_amount_o,
  output logic                 shift_direction_o,
  input  logic [N-1:0]         shifted_data_i
);

  localparam int SH_W = $clog2(N);
  localparam int CW   = (AMT_W > SH_W) ? AMT_W : SH_W;
  localparam logic [CW-1:0] MAX_STEP = CW'(N - 1);

  if (N < 2 || (N & (N - 1)) != 0) begin : g_bad_n
    $error("barrel_shift_sequencer: N must be a power of two >= 2");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [N-1:0]     work;
  logic [AMT_W-1:0] remaining;
  logic             dir;

  logic             accept;
  logic [CW-1:0]    rem_ext;
  logic [SH_W-1:0]  step;
  logic [AMT_W-1:0] rem_next;

  assign accept  = req_valid_i && (state == IDLE);
  assign rem_ext = CW'(remaining);

  // step never exceeds remaining, so the subtraction cannot wrap
  assign step     = (rem_ext < MAX_STEP) ? rem_ext[SH_W-1:0] : SH_W'(N - 1);
  assign rem_next = remaining - AMT_W'(step);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = (req_amount_i == '0) ? DONE : STEP;
        end
      end
      STEP: begin
        if (rem_next == '0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (resp_ready_i) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work      <= '0;
      remaining <= '0;
      dir       <= 1'b0;
    end else if (accept) begin
      work      <= req_data_i;
      remaining <= req_amount_i;
      dir       <= req_direction_i;
    end else if (state == STEP) begin
      work      <= shifted_data_i;
      remaining <= rem_next;
    end
  end

  assign req_ready_o       = (state == IDLE);
  assign resp_valid_o      = (state == DONE);
  assign resp_data_o       = work;
  assign data_o            = work;
  assign shift_direction_o = dir;
  assign shift_amount_o    = (state == STEP) ? step : '0;

endmodule

// File: tb/tb_barrel_shift_sequencer.sv
// Self-checking bench: drives the sequencer with a behavioural rotator attached
// and compares results, per-step shifter commands and latency to a rotate model.
module tb_barrel_shift_sequencer;

  localparam int N     = 8;
  localparam int AMT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             req_valid_i;
  logic             req_ready_o;
  logic [N-1:0]     req_data_i;
  logic [AMT_W-1:0] req_amount_i;
  logic             req_direction_i;
  logic             resp_valid_o;
  logic             resp_ready_i;
  logic [N-1:0]     resp_data_o;
  logic [N-1:0]     data_o;
  logic [2:0]       shift_amount_o;
  logic             shift_direction_o;
  logic [N-1:0]     shifted_data_i;

  int pass_cnt  = 0;
  int check_cnt = 0;

  // observations recorded by run_request
  int         obs_edges;
  logic [7:0] obs_result;
  bit         obs_timeout;
  int         obs_steps[$];
  logic [7:0] obs_data[$];
  logic       obs_dir[$];

  barrel_shift_sequencer #(.N(N), .AMT_W(AMT_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .req_data_i       (req_data_i),
    .req_amount_i     (req_amount_i),
    .req_direction_i  (req_direction_i),
    .resp_valid_o     (resp_valid_o),
    .resp_ready_i     (resp_ready_i),
    .resp_data_o      (resp_data_o),
    .data_o           (data_o),
    .shift_amount_o   (shift_amount_o),
    .shift_direction_o(shift_direction_o),
    .shifted_data_i   (shifted_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference rotate by any amount: amount reduced mod 8 first
  function automatic logic [7:0] rot_ref(input logic [7:0] d, input int amt, input logic right);
    int k;
    k = amt % 8;
    if (right) return (d >> k) | (d << (8 - k));
    else       return (d << k) | (d >> (8 - k));
  endfunction

  assign shifted_data_i = rot_ref(data_o, int'(shift_amount_o), shift_direction_o);

  function automatic int ceil_div7(input int a);
    return (a + 6) / 7;
  endfunction

  task automatic run_request(input logic [7:0] d, input int amt, input logic right);
    int n;
    n = 0;
    while (!req_ready_o && n < 100) begin
      @(posedge clk); #1; n++;
    end
    req_valid_i     = 1'b1;
    req_data_i      = d;
    req_amount_i    = AMT_W'(amt);
    req_direction_i = right;
    @(posedge clk); #1;
    req_valid_i     = 1'b0;
    req_data_i      = 8'($urandom);
    req_amount_i    = 8'($urandom);
    req_direction_i = 1'($urandom);
    obs_steps.delete();
    obs_data.delete();
    obs_dir.delete();
    obs_edges = 1;
    while (!resp_valid_o && obs_edges < 200) begin
      if (!req_ready_o) begin
        obs_steps.push_back(int'(shift_amount_o));
        obs_data.push_back(data_o);
        obs_dir.push_back(shift_direction_o);
      end
      @(posedge clk); #1;
      obs_edges++;
    end
    obs_timeout = !resp_valid_o;
    obs_result  = resp_data_o;
  endtask

  task automatic handshake();
    resp_ready_i = 1'b1;
    @(posedge clk); #1;
    resp_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid_i = 1'b0; req_data_i = 8'hFF; req_amount_i = 8'd9; req_direction_i = 1'b1;
    resp_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_cnt++;
    if ({req_ready_o, resp_valid_o, resp_data_o, data_o, shift_amount_o, shift_direction_o} !== {1'b1, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0})
      $display("FAIL reset_outputs: got rdy=%b vld=%b resp=%h data=%h amt=%0d dir=%b, need 1 0 00 00 0 0",
               req_ready_o, resp_valid_o, resp_data_o, data_o, shift_amount_o, shift_direction_o);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_zero_amount();
    run_request(8'b11110000, 0, 1'b0);
    check_cnt++;
    if (obs_timeout || obs_edges != 1 || obs_steps.size() != 0)
      $display("FAIL zero_latency: got edges=%0d steps=%0d, need 1 and 0", obs_edges, obs_steps.size());
    else pass_cnt++;
    check_cnt++;
    if (obs_result !== 8'b11110000) $display("FAIL zero_result: got %b need 11110000", obs_result);
    else pass_cnt++;
    handshake();
  endtask

  task automatic test_single_step();
    run_request(8'b11110000, 7, 1'b1);
    check_cnt++;
    if (obs_timeout || obs_edges != 2 || obs_steps.size() != 1)
      $display("FAIL one_step_latency: got edges=%0d steps=%0d, need 2 and 1", obs_edges, obs_steps.size());
    else pass_cnt++;
    check_cnt++;
    if (obs_steps.size() != 1 || obs_steps[0] != 7 || obs_dir[0] !== 1'b1)
      $display("FAIL one_step_cmd: got %0d steps, need one step of 7 right", obs_steps.size());
    else pass_cnt++;
    check_cnt++;
    if (obs_result !== 8'b11100001) $display("FAIL one_step_result: got %b need 11100001", obs_result);
    else pass_cnt++;
    handshake();
  endtask

  task automatic test_multi_step();
    run_request(8'b11110000, 20, 1'b0);
    check_cnt++;
    if (obs_timeout || obs_edges != 4 || obs_steps.size() != 3)
      $display("FAIL multi_latency: got edges=%0d steps=%0d, need 4 and 3", obs_edges, obs_steps.size());
    else pass_cnt++;
    check_cnt++;
    if (obs_steps.size() != 3 || obs_steps[0] != 7 || obs_steps[1] != 7 || obs_steps[2] != 6)
      $display("FAIL multi_steps: got %p need 7,7,6", obs_steps);
    else pass_cnt++;
    check_cnt++;
    if (obs_result !== 8'b00001111) $display("FAIL multi_result: got %b need 00001111", obs_result);
    else pass_cnt++;
    handshake();
  endtask

  task automatic test_backpressure();
    logic [7:0] exp;
    bit stable;
    exp = rot_ref(8'hA5, 10, 1'b1);
    run_request(8'hA5, 10, 1'b1);
    stable = !obs_timeout;
    for (int i = 0; i < 5; i++) begin
      req_valid_i  = 1'b1;
      req_data_i   = 8'($urandom);
      req_amount_i = 8'($urandom_range(0, 30));
      @(posedge clk); #1;
      if (!resp_valid_o || resp_data_o !== exp || req_ready_o) stable = 1'b0;
    end
    req_valid_i = 1'b0;
    check_cnt++;
    if (!stable) $display("FAIL hold_stable: got vld=%b resp=%h rdy=%b, need 1 %h 0", resp_valid_o, resp_data_o, req_ready_o, exp);
    else pass_cnt++;
    handshake();
    check_cnt++;
    if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0)
      $display("FAIL handshake_idle: got rdy=%b vld=%b need 1 0", req_ready_o, resp_valid_o);
    else pass_cnt++;
    @(posedge clk); #1;
    check_cnt++;
    if (req_ready_o !== 1'b1 || shift_amount_o !== 3'd0)
      $display("FAIL no_queued_req: got rdy=%b amt=%0d need 1 0", req_ready_o, shift_amount_o);
    else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    bit saw_vld;
    req_valid_i = 1'b1; req_data_i = 8'b11110000; req_amount_i = 8'd20; req_direction_i = 1'b0;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    @(posedge clk); #1;
    check_cnt++;
    if (req_ready_o !== 1'b0 || resp_valid_o !== 1'b0 || shift_amount_o !== 3'd7)
      $display("FAIL abort_in_step: got rdy=%b vld=%b amt=%0d need 0 0 7", req_ready_o, resp_valid_o, shift_amount_o);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    check_cnt++;
    if ({req_ready_o, resp_valid_o, resp_data_o, data_o, shift_amount_o, shift_direction_o} !== {1'b1, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0})
      $display("FAIL abort_outputs: got rdy=%b vld=%b resp=%h data=%h amt=%0d dir=%b, need 1 0 00 00 0 0",
               req_ready_o, resp_valid_o, resp_data_o, data_o, shift_amount_o, shift_direction_o);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    saw_vld = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (resp_valid_o) saw_vld = 1'b1;
    end
    check_cnt++;
    if (saw_vld) $display("FAIL abort_no_resp: got resp_valid after reset, need none");
    else pass_cnt++;
    run_request(8'b10000000, 1, 1'b0);
    check_cnt++;
    if (obs_timeout || obs_edges != 2 || obs_result !== 8'b00000001)
      $display("FAIL post_reset_req: got edges=%0d result=%b need 2 00000001", obs_edges, obs_result);
    else pass_cnt++;
    handshake();
  endtask

  task automatic test_random_sweep();
    int errs_res, errs_lat, errs_step, errs_hold, errs_idle;
    errs_res = 0; errs_lat = 0; errs_step = 0; errs_hold = 0; errs_idle = 0;
    for (int r = 0; r < 1000; r++) begin
      logic [7:0] d;
      int amt, rem, cum, hold;
      logic right;
      bit bad;
      d     = 8'($urandom);
      amt   = (r % 10 == 0) ? 0 : int'($urandom_range(0, 255));
      right = 1'($urandom);
      hold  = int'($urandom_range(0, 3));
      run_request(d, amt, right);
      if (obs_timeout || obs_result !== rot_ref(d, amt, right)) begin
        if (errs_res < 3) $display("FAIL rand_result: d=%h amt=%0d dir=%b got %h need %h", d, amt, right, obs_result, rot_ref(d, amt, right));
        errs_res++;
      end
      if (obs_edges != 1 + ceil_div7(amt)) begin
        if (errs_lat < 3) $display("FAIL rand_latency: amt=%0d got %0d edges need %0d", amt, obs_edges, 1 + ceil_div7(amt));
        errs_lat++;
      end
      bad = (obs_steps.size() != ceil_div7(amt));
      rem = amt; cum = 0;
      for (int s = 0; s < obs_steps.size() && !bad; s++) begin
        if (obs_steps[s] != ((rem < 7) ? rem : 7) || obs_dir[s] !== right || obs_data[s] !== rot_ref(d, cum, right)) bad = 1'b1;
        cum += obs_steps[s];
        rem -= obs_steps[s];
      end
      if (bad) begin
        if (errs_step < 3) $display("FAIL rand_steps: d=%h amt=%0d dir=%b got steps %p", d, amt, right, obs_steps);
        errs_step++;
      end
      for (int h = 0; h < hold; h++) begin
        req_valid_i = 1'($urandom);
        @(posedge clk); #1;
        if (!resp_valid_o || req_ready_o || resp_data_o !== rot_ref(d, amt, right)) errs_hold++;
      end
      req_valid_i = 1'b0;
      handshake();
      if (!req_ready_o || resp_valid_o) errs_idle++;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    check_cnt++;
    if (errs_res != 0) $display("FAIL rand_results: got %0d bad results need 0", errs_res); else pass_cnt++;
    check_cnt++;
    if (errs_lat != 0) $display("FAIL rand_latencies: got %0d bad latencies need 0", errs_lat); else pass_cnt++;
    check_cnt++;
    if (errs_step != 0) $display("FAIL rand_step_cmds: got %0d bad step sequences need 0", errs_step); else pass_cnt++;
    check_cnt++;
    if (errs_hold != 0) $display("FAIL rand_hold: got %0d unstable hold cycles need 0", errs_hold); else pass_cnt++;
    check_cnt++;
    if (errs_idle != 0) $display("FAIL rand_return_idle: got %0d bad handshakes need 0", errs_idle); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_zero_amount();
    test_single_step();
    test_multi_step();
    test_backpressure();
    test_reset_abort();
    test_random_sweep();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
